// File: rtl/spike_fb_pkg.sv
// spike_fb_pkg -- shared types and helpers for the spike framebuffer scan path.
// Rev 1.0
`default_nettype none

package spike_fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  function automatic int unsigned clamp_count(int unsigned req, int unsigned limit);
    return (req > limit) ? limit : req;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spike_pending_map.sv
// spike_pending_map -- per-neuron pending-spike bitmap with set and sample-and-clear ports.
// Rev 1.0
`default_nettype none

module spike_pending_map
  import spike_fb_pkg::*;
#(
  parameter int N_NEURONS = 256,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_valid,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  output logic             clr_bit
);

  logic [N_NEURONS-1:0] bits;
  logic [N_NEURONS-1:0] set_mask;
  logic [N_NEURONS-1:0] clr_mask;
  logic                 set_ok;

  generate
    if (N_NEURONS == (1 << IDX_W)) begin : g_full_range
      assign set_ok = 1'b1;
    end else begin : g_part_range
      assign set_ok = {1'b0, set_idx} < (IDX_W+1)'(N_NEURONS);
    end
  endgenerate

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    clr_bit  = 1'b0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (set_idx == IDX_W'(k)) set_mask[k] = set_valid & set_ok;
      if (clr_idx == IDX_W'(k)) begin
        clr_mask[k] = clr_en;
        clr_bit     = bits[k];
      end
    end
  end

  // Set is applied after clear so a same-cycle spike survives the scan.
  always_ff @(posedge clk) begin
    if (rst) bits <= '0;
    else     bits <= (bits & ~clr_mask) | set_mask;
  end

endmodule

`default_nettype wire

// File: rtl/spike_fb_scan_ctrl.sv
// spike_fb_scan_ctrl -- frame-scan scheduler merging membrane voltages with pending spikes.
// Rev 1.0
`default_nettype none

module spike_fb_scan_ctrl
  import spike_fb_pkg::*;
#(
  parameter int WIDTH             = 32,
  parameter int NEURON_ADDR_WIDTH = 8,
  parameter int N_NEURONS         = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic [NEURON_ADDR_WIDTH:0]   n_active,
  input  logic                         spike_in_valid,
  input  logic [NEURON_ADDR_WIDTH-1:0] spike_in_idx,
  output logic                         vmem_rd_en,
  output logic [NEURON_ADDR_WIDTH-1:0] vmem_rd_addr,
  input  logic [WIDTH-1:0]             vmem_rd_data,
  output logic                         px_valid,
  output logic                         px_spike,
  output logic [NEURON_ADDR_WIDTH-1:0] px_idx,
  output logic [WIDTH-1:0]             px_v,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);

  localparam int CNT_W = NEURON_ADDR_WIDTH + 1;

  scan_state_t                  state, state_nxt;
  logic [NEURON_ADDR_WIDTH-1:0] cnt;
  logic [CNT_W-1:0]             n_lat;
  logic [CNT_W-1:0]             n_req;
  logic                         last_addr;
  logic                         pend_bit;
  logic                         accept;
  logic                         s1_valid;
  logic                         s1_pend;
  logic [NEURON_ADDR_WIDTH-1:0] s1_idx;

  assign n_req     = CNT_W'(clamp_count(32'(n_active), N_NEURONS));
  assign last_addr = ({1'b0, cnt} == n_lat - 1'b1);
  assign accept    = frame_start && (state == IDLE);
  assign vmem_rd_addr = cnt;

  spike_pending_map #(
    .N_NEURONS (N_NEURONS),
    .IDX_W     (NEURON_ADDR_WIDTH)
  ) u_pending (
    .clk       (clk),
    .rst       (rst),
    .set_valid (spike_in_valid),
    .set_idx   (spike_in_idx),
    .clr_en    (vmem_rd_en),
    .clr_idx   (cnt),
    .clr_bit   (pend_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    vmem_rd_en = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (frame_start) state_nxt = (n_req == '0) ? DONE : SCAN;
      end
      SCAN: begin
        vmem_rd_en = 1'b1;
        if (last_addr) state_nxt = DRAIN;
      end
      // Last pixel is on the output once the read stage has emptied.
      DRAIN: if (!s1_valid && px_valid) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      n_lat    <= '0;
      overrun  <= 1'b0;
      s1_valid <= 1'b0;
      s1_pend  <= 1'b0;
      s1_idx   <= '0;
      px_valid <= 1'b0;
      px_spike <= 1'b0;
      px_idx   <= '0;
      px_v     <= '0;
    end else begin
      if (accept) begin
        n_lat <= n_req;
        cnt   <= '0;
      end else if (vmem_rd_en) begin
        cnt <= last_addr ? '0 : cnt + 1'b1;
      end
      if (frame_start && state != IDLE) overrun <= 1'b1;
      s1_valid <= vmem_rd_en;
      s1_pend  <= vmem_rd_en & pend_bit;
      s1_idx   <= cnt;
      px_valid <= s1_valid;
      px_spike <= s1_valid & s1_pend;
      if (s1_valid) begin
        px_idx <= s1_idx;
        px_v   <= vmem_rd_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spike_fb_scan_ctrl.sv
// tb_spike_fb_scan_ctrl -- directed self-checking bench for the frame-scan scheduler.
// Rev 1.0
`default_nettype none

module tb_spike_fb_scan_ctrl;

  localparam int W = 32;
  localparam int A = 8;
  localparam int N = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_start;
  logic [A:0]   n_active;
  logic         spike_in_valid;
  logic [A-1:0] spike_in_idx;
  logic         vmem_rd_en;
  logic [A-1:0] vmem_rd_addr;
  logic [W-1:0] vmem_rd_data;
  logic         px_valid;
  logic         px_spike;
  logic [A-1:0] px_idx;
  logic [W-1:0] px_v;
  logic         busy;
  logic         frame_done;
  logic         overrun;

  spike_fb_scan_ctrl #(.WIDTH(W), .NEURON_ADDR_WIDTH(A), .N_NEURONS(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .n_active       (n_active),
    .spike_in_valid (spike_in_valid),
    .spike_in_idx   (spike_in_idx),
    .vmem_rd_en     (vmem_rd_en),
    .vmem_rd_addr   (vmem_rd_addr),
    .vmem_rd_data   (vmem_rd_data),
    .px_valid       (px_valid),
    .px_spike       (px_spike),
    .px_idx         (px_idx),
    .px_v           (px_v),
    .busy           (busy),
    .frame_done     (frame_done),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int voff = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Voltage memory model: one-cycle read latency, contents 100*addr + voff.
  always @(posedge clk)
    vmem_rd_data <= vmem_rd_en ? 32'(voff + 100 * int'(vmem_rd_addr)) : 32'hDEADBEEF;

  typedef struct {
    int         c;
    int         idx;
    logic       sp;
    logic [W-1:0] v;
  } px_t;

  px_t px_q[$];
  int  done_q[$];
  int  rd_count, busy_count, first_rd;
  int  checks = 0;
  int  errors = 0;

  always @(negedge clk) begin
    if (px_valid) px_q.push_back(px_t'{cyc, int'(px_idx), px_spike, px_v});
    if (frame_done) done_q.push_back(cyc);
    if (vmem_rd_en) begin
      if (rd_count == 0) first_rd = cyc;
      rd_count++;
    end
    if (busy) busy_count++;
  end

  task automatic clear_logs();
    px_q.delete();
    done_q.delete();
    rd_count   = 0;
    busy_count = 0;
    first_rd   = -1;
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(input int n, output int t);
    n_active    = (A+1)'(n);
    frame_start = 1'b1;
    t           = cyc;
    step(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int k = 0;
    while (done_q.size() == 0 && k < bound) begin
      step(1);
      k++;
    end
    checks++;
    if (done_q.size() == 0) begin
      errors++;
      $display("FAIL %s_timeout: frame_done not seen, required within %0d cycles", name, bound);
    end
  endtask

  task automatic pulse_spike(input int idx);
    spike_in_valid = 1'b1;
    spike_in_idx   = A'(idx);
    step(1);
    spike_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({vmem_rd_en, px_valid, px_spike, busy, frame_done, overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000",
               {vmem_rd_en, px_valid, px_spike, busy, frame_done, overrun});
    end
    checks++;
    if (px_idx !== '0) begin errors++; $display("FAIL reset_px_idx: got %0d required 0", px_idx); end
    checks++;
    if (px_v !== '0) begin errors++; $display("FAIL reset_px_v: got %0h required 0", px_v); end
    checks++;
    if (vmem_rd_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d required 0", vmem_rd_addr); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_basic();
    int t;
    voff = 0;
    clear_logs();
    start_frame(4, t);
    wait_done(20, "basic");
    step(2);
    checks++;
    if (px_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d required 4", px_q.size()); end
    foreach (px_q[i]) begin
      checks++;
      if (px_q[i].c != t+3+i || px_q[i].idx != i || px_q[i].v !== 32'(100*i) || px_q[i].sp !== 1'b0) begin
        errors++;
        $display("FAIL basic_px%0d: got cyc %0d idx %0d v %0d sp %b required cyc %0d idx %0d v %0d sp 0",
                 i, px_q[i].c - t, px_q[i].idx, px_q[i].v, px_q[i].sp, 3+i, i, 100*i);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != t+7) begin
      errors++; $display("FAIL basic_done: got %0d pulses at T+%0d required 1 at T+7", done_q.size(), done_q[0]-t);
    end
    checks++;
    if (first_rd != t+1 || rd_count != 4) begin
      errors++; $display("FAIL basic_reads: got first T+%0d count %0d required T+1 count 4", first_rd-t, rd_count);
    end
    checks++;
    if (busy_count != 7) begin errors++; $display("FAIL basic_busy: got %0d cycles required 7", busy_count); end
  endtask

  task automatic test_spike_collapse();
    int t;
    voff = -1000;
    spike_in_valid = 1'b1;
    spike_in_idx   = 8'd2;
    step(2);
    spike_in_valid = 1'b0;
    step(1);
    for (int f = 0; f < 2; f++) begin
      clear_logs();
      start_frame(4, t);
      wait_done(20, "collapse");
      step(1);
      checks++;
      if (px_q.size() != 4) begin errors++; $display("FAIL collapse_count%0d: got %0d required 4", f, px_q.size()); end
      foreach (px_q[i]) begin
        checks++;
        if (px_q[i].idx != i || px_q[i].sp !== (f == 0 && i == 2) || px_q[i].v !== 32'(100*i - 1000)) begin
          errors++;
          $display("FAIL collapse_f%0d_px%0d: got idx %0d sp %b v %0d required idx %0d sp %b v %0d",
                   f, i, px_q[i].idx, px_q[i].sp, $signed(px_q[i].v), i, (f == 0 && i == 2), 100*i - 1000);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    int t;
    voff = 0;
    for (int f = 0; f < 2; f++) begin
      clear_logs();
      start_frame(8, t);
      if (f == 0) begin
        step(5);
        checks++;
        if (vmem_rd_en !== 1'b1 || vmem_rd_addr !== 8'd5) begin
          errors++; $display("FAIL same_addr: got en %b addr %0d at T+6 required en 1 addr 5", vmem_rd_en, vmem_rd_addr);
        end
        pulse_spike(5);
      end
      wait_done(30, "same");
      step(1);
      checks++;
      if (px_q.size() != 8) begin errors++; $display("FAIL same_count%0d: got %0d required 8", f, px_q.size()); end
      foreach (px_q[i]) begin
        checks++;
        if (px_q[i].idx != i || px_q[i].sp !== (f == 1 && i == 5)) begin
          errors++;
          $display("FAIL same_f%0d_px%0d: got idx %0d sp %b required idx %0d sp %b",
                   f, i, px_q[i].idx, px_q[i].sp, i, (f == 1 && i == 5));
        end
      end
    end
  endtask

  task automatic test_zero();
    int t;
    clear_logs();
    start_frame(0, t);
    wait_done(10, "zero");
    step(2);
    checks++;
    if (done_q.size() != 1 || done_q[0] != t+1) begin
      errors++; $display("FAIL zero_done: got %0d pulses at T+%0d required 1 at T+1", done_q.size(), done_q[0]-t);
    end
    checks++;
    if (rd_count != 0 || px_q.size() != 0) begin
      errors++; $display("FAIL zero_activity: got reads %0d px %0d required 0 0", rd_count, px_q.size());
    end
    checks++;
    if (busy_count != 1) begin errors++; $display("FAIL zero_busy: got %0d required 1", busy_count); end
  endtask

  task automatic test_clamp();
    int t;
    int bad;
    clear_logs();
    start_frame(300, t);
    wait_done(300, "clamp");
    step(1);
    checks++;
    if (px_q.size() != 256 || rd_count != 256) begin
      errors++; $display("FAIL clamp_count: got px %0d reads %0d required 256 256", px_q.size(), rd_count);
    end
    bad = 0;
    foreach (px_q[i]) if (px_q[i].idx != i || px_q[i].c != t+3+i || px_q[i].sp !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clamp_seq: got %0d bad entries required 0", bad); end
    checks++;
    if (px_q.size() == 0 || px_q[px_q.size()-1].idx != 255) begin
      errors++; $display("FAIL clamp_last: got last idx %0d required 255", (px_q.size() == 0) ? -1 : px_q[px_q.size()-1].idx);
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != t+259) begin
      errors++; $display("FAIL clamp_done: got T+%0d required T+259", done_q[0]-t);
    end
  endtask

  task automatic test_overrun_done();
    int t;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial: got %b required 0", overrun); end
    clear_logs();
    start_frame(4, t);
    step(6);
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL ovr_done_cycle: got frame_done %b at T+7 required 1", frame_done); end
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    step(6);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_in_done: got %b required 1", overrun); end
    checks++;
    if (busy_count != 7 || done_q.size() != 1) begin
      errors++; $display("FAIL ovr_dropped: got busy %0d done %0d required 7 1", busy_count, done_q.size());
    end
  endtask

  task automatic test_overrun_scan();
    int t;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_rst_clear: got %b required 0", overrun); end
    clear_logs();
    start_frame(4, t);
    step(1);
    n_active    = 9'd8;
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    wait_done(20, "ovr_scan");
    step(1);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_in_scan: got %b required 1", overrun); end
    checks++;
    if (px_q.size() != 4 || done_q[0] != t+7) begin
      errors++; $display("FAIL ovr_scan_frame: got px %0d done T+%0d required 4 T+7", px_q.size(), done_q[0]-t);
    end
    clear_logs();
    start_frame(2, t);
    wait_done(20, "ovr_next");
    step(1);
    checks++;
    if (overrun !== 1'b1 || px_q.size() != 2) begin
      errors++; $display("FAIL ovr_sticky: got overrun %b px %0d required 1 2", overrun, px_q.size());
    end
  endtask

  task automatic test_rst_mid();
    int t;
    int late;
    pulse_spike(6);
    pulse_spike(7);
    clear_logs();
    start_frame(8, t);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({px_valid, busy, vmem_rd_en, px_spike} !== 4'b0 || px_idx !== '0 || px_v !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got valid %b busy %b rd %b idx %0d v %0d required all 0",
                         px_valid, busy, vmem_rd_en, px_idx, px_v);
    end
    step(12);
    late = 0;
    foreach (px_q[i]) if (px_q[i].c >= t+5) late++;
    checks++;
    if (late != 0 || px_q.size() != 2) begin
      errors++; $display("FAIL rst_mid_px: got late %0d total %0d required 0 2", late, px_q.size());
    end
    checks++;
    if (done_q.size() != 0) begin errors++; $display("FAIL rst_mid_done: got %0d pulses required 0", done_q.size()); end
    clear_logs();
    start_frame(8, t);
    wait_done(30, "rst_next");
    step(1);
    checks++;
    if (px_q.size() != 8) begin errors++; $display("FAIL rst_next_count: got %0d required 8", px_q.size()); end
    foreach (px_q[i]) begin
      checks++;
      if (px_q[i].idx != i || px_q[i].sp !== 1'b0) begin
        errors++; $display("FAIL rst_next_px%0d: got idx %0d sp %b required idx %0d sp 0", i, px_q[i].idx, px_q[i].sp, i);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    frame_start    = 1'b0;
    n_active       = '0;
    spike_in_valid = 1'b0;
    spike_in_idx   = '0;
    clear_logs();
    test_reset();
    test_basic();
    test_spike_collapse();
    test_same_cycle();
    test_zero();
    test_clamp();
    test_overrun_done();
    test_overrun_scan();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion within 50000 cycles");
    $fatal(1);
  end

endmodule

`default_nettype wire
